// File: rtl/mem_stage.sv
// Memory stage of a 5-stage pipeline: EX/MEM and MEM/WB registers plus a
// data-bus handshake with wait-state stalling and a sticky timeout error.
module mem_stage #(
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_RegWriteE,
  input  logic               i_MemtoRegE,
  input  logic               i_MemWriteE,
  input  logic [D_WIDTH-1:0] i_ALUResultE,
  input  logic [D_WIDTH-1:0] i_WriteDataE,
  input  logic [3:0]         i_WA3E,
  input  logic               i_DAck,
  input  logic [D_WIDTH-1:0] i_DRData,
  output logic               o_DReq,
  output logic               o_DWe,
  output logic [D_WIDTH-1:0] o_DAddr,
  output logic [D_WIDTH-1:0] o_DWData,
  output logic               o_StallM,
  output logic               o_RegWriteM,
  output logic [3:0]         o_WA3M,
  output logic [D_WIDTH-1:0] o_ALUResultM,
  output logic               o_RegWriteW,
  output logic               o_MemtoRegW,
  output logic [D_WIDTH-1:0] o_ALUResultW,
  output logic [D_WIDTH-1:0] o_ReadDataW,
  output logic [3:0]         o_WA3W,
  output logic               o_BusErr
);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t             state;
  logic [7:0]         cnt;
  logic               bus_err;

  logic               reg_write_m, mem_to_reg_m, mem_write_m;
  logic [D_WIDTH-1:0] alu_result_m, write_data_m;
  logic [3:0]         wa3_m;

  logic               reg_write_w, mem_to_reg_w;
  logic [D_WIDTH-1:0] alu_result_w, read_data_w;
  logic [3:0]         wa3_w;

  logic mem_op, dreq, stall;

  assign mem_op = mem_write_m | mem_to_reg_m;
  assign dreq   = mem_op && (state != ERR);
  assign stall  = dreq && !i_DAck;

  // EX/MEM register: frozen while the bus access is waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      mem_write_m  <= 1'b0;
      alu_result_m <= '0;
      write_data_m <= '0;
      wa3_m        <= '0;
    end else if (!stall) begin
      reg_write_m  <= i_RegWriteE;
      mem_to_reg_m <= i_MemtoRegE;
      mem_write_m  <= i_MemWriteE;
      alu_result_m <= i_ALUResultE;
      write_data_m <= i_WriteDataE;
      wa3_m        <= i_WA3E;
    end
  end

  // cnt holds the number of unacknowledged request cycles already spent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !i_DAck) begin
            state <= BUSY;
            cnt   <= 8'd1;
          end
        end
        BUSY: begin
          if (i_DAck) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state   <= ERR;
            cnt     <= '0;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, a timed-out op retires without writing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      alu_result_w <= '0;
      wa3_w        <= '0;
    end else if (stall) begin
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
    end else begin
      reg_write_w  <= reg_write_m && (state != ERR);
      mem_to_reg_w <= mem_to_reg_m;
      alu_result_w <= alu_result_m;
      wa3_w        <= wa3_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_w <= '0;
    end else if (dreq && !mem_write_m && i_DAck) begin
      read_data_w <= i_DRData;
    end
  end

  assign o_DReq       = dreq;
  assign o_DWe        = dreq && mem_write_m;
  assign o_DAddr      = alu_result_m;
  assign o_DWData     = write_data_m;
  assign o_StallM     = stall;
  assign o_RegWriteM  = reg_write_m;
  assign o_WA3M       = wa3_m;
  assign o_ALUResultM = alu_result_m;
  assign o_RegWriteW  = reg_write_w;
  assign o_MemtoRegW  = mem_to_reg_w;
  assign o_ALUResultW = alu_result_w;
  assign o_ReadDataW  = read_data_w;
  assign o_WA3W       = wa3_w;
  assign o_BusErr     = bus_err;

endmodule
